// File: rtl/vta_pkg.sv
// Shared VTA instruction-layout constants and the dispatcher state encoding.
package vta_pkg;

  localparam logic [2:0] OPC_LOAD   = 3'd0;
  localparam logic [2:0] OPC_STORE  = 3'd1;
  localparam logic [2:0] OPC_GEMM   = 3'd2;
  localparam logic [2:0] OPC_FINISH = 3'd3;
  localparam logic [2:0] OPC_ALU    = 3'd4;

  localparam int OPC_LSB      = 0;
  localparam int OPC_W        = 3;
  localparam int UOP_BGN_LSB  = 8;
  localparam int UOP_BGN_W    = 13;
  localparam int UOP_END_LSB  = 21;
  localparam int UOP_END_W    = 14;
  localparam int ITER_OUT_LSB = 35;
  localparam int ITER_OUT_W   = 14;
  localparam int ITER_IN_LSB  = 49;
  localparam int ITER_IN_W    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/gemm_insn_fifo.sv
// Instruction buffer: register-array FIFO with the head word presented combinationally.
module gemm_insn_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  // Full blocks the write even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/gemm_insn_dispatch.sv
// Buffers VTA instructions, drops/counts non-compute ones, and issues legal
// GEMM/ALU instructions to the gemm core one at a time.
module gemm_insn_dispatch
  import vta_pkg::*;
#(
  parameter int INS_WIDTH  = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [INS_WIDTH-1:0]          s_insn_data,
  input  logic                          s_insn_valid,
  output logic                          s_insn_ready,
  output logic [INS_WIDTH-1:0]          insn,
  output logic                          insn_valid,
  input  logic                          insn_ready,
  input  logic                          gemm_done,
  output logic                          busy,
  output logic                          finish,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]          issue_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [CNT_WIDTH-1:0]          err_cnt
);

  state_e                state_q;
  logic [INS_WIDTH-1:0]  insn_q;
  logic                  finish_q;
  logic [CNT_WIDTH-1:0]  issue_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;

  logic [INS_WIDTH-1:0]  head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [OPC_W-1:0]      head_opc;
  logic [UOP_BGN_W-1:0]  head_uop_bgn;
  logic [UOP_END_W-1:0]  head_uop_end;
  logic [ITER_OUT_W-1:0] head_iter_out;
  logic [ITER_IN_W-1:0]  head_iter_in;
  logic                  is_compute;
  logic                  fields_ok;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  gemm_insn_fifo #(
    .W     (INS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (s_insn_valid),
    .data_i  (s_insn_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign pop           = (state_q == ST_IDLE) && !fifo_empty;
  assign head_opc      = head[OPC_LSB +: OPC_W];
  assign head_uop_bgn  = head[UOP_BGN_LSB +: UOP_BGN_W];
  assign head_uop_end  = head[UOP_END_LSB +: UOP_END_W];
  assign head_iter_out = head[ITER_OUT_LSB +: ITER_OUT_W];
  assign head_iter_in  = head[ITER_IN_LSB +: ITER_IN_W];
  assign is_compute    = (head_opc == OPC_GEMM) || (head_opc == OPC_ALU);
  // An empty uop range or a zero loop bound would make the core spin on nothing.
  assign fields_ok     = (head_uop_end > {1'b0, head_uop_bgn}) &&
                         (head_iter_out != '0) && (head_iter_in != '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      insn_q      <= '0;
      finish_q    <= 1'b0;
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (is_compute) begin
              if (fields_ok) begin
                insn_q  <= head;
                state_q <= ST_ISSUE;
              end else begin
                err_cnt_q <= sat_inc(err_cnt_q);
              end
            end else if (head_opc == OPC_FINISH) begin
              finish_q <= 1'b1;
            end else begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end
          end
        end
        ST_ISSUE: begin
          if (insn_ready) begin
            issue_cnt_q <= sat_inc(issue_cnt_q);
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (gemm_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_insn_ready = !fifo_full;
  assign insn         = insn_q;
  assign insn_valid   = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign finish       = finish_q;
  assign issue_cnt    = issue_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule
